// File: rtl/byte_pair_sequencer.sv
// byte_pair_sequencer: pairs an incoming byte stream into N-bit words and drives the
// data, load strobes and clear of a downstream split-half load register. The word is
// held (word_valid) until the consumer acknowledges it. In atomic mode both halves are
// written in the same cycle so the register never shows a mixed old/new word.
module byte_pair_sequencer #(
    parameter int unsigned N        = 16,
    parameter bit          HI_FIRST = 1'b1,
    parameter bit          ATOMIC   = 1'b0,
    parameter int unsigned CW       = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [N/2-1:0]   byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             flush,
    input  logic             word_ack,
    output logic [N/2-1:0]   inh,
    output logic [N/2-1:0]   inl,
    output logic             loadh,
    output logic             loadl,
    output logic             reg_clear,
    output logic             word_valid,
    output logic [CW-1:0]    word_count
);

    typedef enum logic [1:0] {
        StEmpty,
        StHalf,
        StCommit,
        StFull
    } state_e;

    state_e state;
    logic   accept;

    // Ready only while collecting bytes; held low during reset and while flushing.
    always_comb begin
        byte_ready = clear_n & ~flush & ((state == StEmpty) | (state == StHalf));
        accept     = byte_valid & byte_ready;
        word_valid = (state == StFull);
    end

    // Sequencer: state, captured bytes, one-cycle strobes, clear pulse and word counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= StEmpty;
            inh        <= '0;
            inl        <= '0;
            loadh      <= 1'b0;
            loadl      <= 1'b0;
            reg_clear  <= 1'b0;
            word_count <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            loadh     <= 1'b0;
            loadl     <= 1'b0;
            reg_clear <= flush;
            if (flush) begin
                // Flush drops any partial or held word; the counter is untouched.
                state <= StEmpty;
            end else begin
                case (state)
                    StEmpty: begin
                        if (accept) begin
                            state <= StHalf;
                            if (HI_FIRST) begin
                                inh   <= byte_in;
                                loadh <= ~ATOMIC;
                            end else begin
                                inl   <= byte_in;
                                loadl <= ~ATOMIC;
                            end
                        end
                    end
                    StHalf: begin
                        if (accept) begin
                            state <= StCommit;
                            // Atomic mode also re-strobes the first half, written together.
                            if (HI_FIRST) begin
                                inl   <= byte_in;
                                loadl <= 1'b1;
                                loadh <= ATOMIC;
                            end else begin
                                inh   <= byte_in;
                                loadh <= 1'b1;
                                loadl <= ATOMIC;
                            end
                        end
                    end
                    StCommit: begin
                        state <= StFull;
                    end
                    StFull: begin
                        if (word_ack) begin
                            word_count <= word_count + CW'(1);
                            state      <= StEmpty;
                        end
                    end
                    default: begin
                        state <= StEmpty;
                    end
                endcase
            end
        end
    end

    // Both strobes together only make sense for an atomic commit.
    a_strobe_pair: assert property (@(posedge clk) disable iff (!clear_n)
        (loadh && loadl) |-> ATOMIC);

    // A clear cycle never carries a load.
    a_clear_excl: assert property (@(posedge clk) disable iff (!clear_n)
        reg_clear |-> (!loadh && !loadl));

endmodule

// File: tb/tb_byte_pair_sequencer.sv
// Bench for byte_pair_sequencer: three instances (HI_FIRST/ATOMIC/CW variants) share one
// directed stimulus stream; a transaction-level model checks every cycle and literal
// expectations pin the scenarios.
module tb_byte_pair_sequencer;

    localparam bit [2:0] HF = 3'b101;
    localparam bit [2:0] AT = 3'b010;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       flush;
    logic       word_ack;

    logic       ready_w [3];
    logic       lh_w    [3];
    logic       ll_w    [3];
    logic       clr_w   [3];
    logic       wv_w    [3];
    logic [7:0] inh_w   [3];
    logic [7:0] inl_w   [3];
    logic [7:0] cnt_w   [3];
    logic [15:0] dreg   [3];

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned CWG = (g == 2) ? 2 : 8;
        logic [CWG-1:0] cnt;
        byte_pair_sequencer #(
            .N       (16),
            .HI_FIRST(HF[g]),
            .ATOMIC  (AT[g]),
            .CW      (CWG)
        ) u_dut (
            .clk       (clk),
            .clear_n   (clear_n),
            .byte_in   (byte_in),
            .byte_valid(byte_valid),
            .byte_ready(ready_w[g]),
            .flush     (flush),
            .word_ack  (word_ack),
            .inh       (inh_w[g]),
            .inl       (inl_w[g]),
            .loadh     (lh_w[g]),
            .loadl     (ll_w[g]),
            .reg_clear (clr_w[g]),
            .word_valid(wv_w[g]),
            .word_count(cnt)
        );
        assign cnt_w[g] = 8'(cnt);
    end

    // Downstream split-half register driven by each instance.
    always @(posedge clk or negedge clear_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!clear_n || clr_w[i]) begin
                dreg[i] <= 16'h0000;
            end else begin
                if (lh_w[i]) dreg[i][15:8] <= inh_w[i];
                if (ll_w[i]) dreg[i][7:0]  <= inl_w[i];
            end
        end
    end

    // Model: bytes held for the current word, whether it is committing or waiting for ack.
    typedef struct {
        int         nb;
        bit         commit;
        bit         full;
        logic [7:0] first;
        logic [7:0] second;
        logic [7:0] inh;
        logic [7:0] inl;
        bit         lh;
        bit         ll;
        bit         clr;
        int         count;
    } mdl_t;

    mdl_t mdl [3];

    always @(posedge clk or negedge clear_n) begin : upd
        mdl_t m;
        for (int i = 0; i < 3; i++) begin
            m = mdl[i];
            if (!clear_n) begin
                m = '{default: 0};
            end else begin
                m.lh  = 1'b0;
                m.ll  = 1'b0;
                m.clr = flush;
                if (flush) begin
                    m.nb = 0; m.commit = 1'b0; m.full = 1'b0;
                end else if (m.full) begin
                    if (word_ack) begin
                        m.count = (m.count + 1) % ((i == 2) ? 4 : 256);
                        m.full  = 1'b0;
                    end
                end else if (m.commit) begin
                    m.commit = 1'b0;
                    m.full   = 1'b1;
                end else if (byte_valid) begin
                    if (m.nb == 0) begin
                        m.first = byte_in;
                        m.nb    = 1;
                        if (HF[i]) m.inh = byte_in; else m.inl = byte_in;
                        if (!AT[i]) begin
                            if (HF[i]) m.lh = 1'b1; else m.ll = 1'b1;
                        end
                    end else begin
                        m.second = byte_in;
                        m.nb     = 0;
                        m.commit = 1'b1;
                        if (HF[i]) m.inl = byte_in; else m.inh = byte_in;
                        if (AT[i]) begin
                            m.lh = 1'b1; m.ll = 1'b1;
                        end else if (HF[i]) begin
                            m.ll = 1'b1;
                        end else begin
                            m.lh = 1'b1;
                        end
                    end
                end
            end
            mdl[i] <= m;
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, i, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin : cmp
        mdl_t m;
        if (run) begin
            for (int i = 0; i < 3; i++) begin
                m = mdl[i];
                chk("byte_ready", i, ready_w[i], clear_n && !flush && !m.commit && !m.full);
                chk("word_valid", i, wv_w[i], m.full);
                chk("loadh", i, lh_w[i], m.lh);
                chk("loadl", i, ll_w[i], m.ll);
                chk("reg_clear", i, clr_w[i], m.clr);
                chk("inh", i, inh_w[i], m.inh);
                chk("inl", i, inl_w[i], m.inl);
                chk("word_count", i, cnt_w[i], m.count);
                if (m.full)
                    chk("register", i, dreg[i], HF[i] ? {m.first, m.second} : {m.second, m.first});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present a byte until the edge that accepts it (bounded).
    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #3;
            done = ready_w[0];
            cyc();
        end
        byte_valid = 1'b0;
        chk("accepted", 0, done, 1);
    endtask

    task automatic ack();
        word_ack = 1'b1;
        cyc();
        word_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_c [5] = '{1, 2, 3, 0, 1};
        clear_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; word_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        run = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            chk("rst_count", i, cnt_w[i], 0);
            chk("rst_ready", i, ready_w[i], 0);
            chk("rst_inh", i, inh_w[i], 0);
        end
        cyc();
        clear_n = 1'b1;
        cyc();

        // 1: back-to-back pair, high half first, split writes
        send(8'hA5);
        send(8'h3C);
        #3;
        chk("t1_loadl", 0, ll_w[0], 1);
        chk("t1_loadh", 0, lh_w[0], 0);
        chk("t1_inl", 0, inl_w[0], 8'h3C);
        chk("t1_inh", 0, inh_w[0], 8'hA5);
        cyc();
        #3;
        chk("t1_valid", 0, wv_w[0], 1);
        chk("t1_reg", 0, dreg[0], 16'hA53C);
        chk("t1_reg_atomic", 1, dreg[1], 16'h3CA5);
        cyc();
        ack();

        // 2: atomic, low half first
        send(8'h11);
        #3;
        chk("t2_no_strobe", 1, {lh_w[1], ll_w[1]}, 2'b00);
        chk("t2_inl", 1, inl_w[1], 8'h11);
        cyc();
        send(8'h22);
        #3;
        chk("t2_both", 1, {lh_w[1], ll_w[1]}, 2'b11);
        chk("t2_inh", 1, inh_w[1], 8'h22);
        cyc();
        #3;
        chk("t2_reg", 1, dreg[1], 16'h2211);
        cyc();
        ack();

        // 3: backpressure while word is held
        send(8'h01);
        #3;
        chk("t3_first_strobe", 0, lh_w[0], 1);
        chk("t3_first_inh", 0, inh_w[0], 8'h01);
        cyc();
        send(8'h02);
        cyc();
        byte_in = 8'h03;
        byte_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #3;
            chk("t3_ready_low", 0, ready_w[0], 0);
            chk("t3_valid_held", 0, wv_w[0], 1);
            cyc();
        end
        word_ack = 1'b1;
        cyc();
        word_ack = 1'b0;
        #3;
        chk("t3_count", 0, cnt_w[0], 3);
        chk("t3_ready_again", 0, ready_w[0], 1);
        cyc();
        byte_in = 8'h04;
        cyc();
        byte_valid = 1'b0;
        cyc();
        #3;
        chk("t3_reg", 0, dreg[0], 16'h0304);
        cyc();
        ack();

        // 4: flush in HALF, held two cycles, then a fresh pair
        send(8'h55);
        flush = 1'b1;
        cyc();
        #3;
        chk("t4_ready_flush", 0, ready_w[0], 0);
        chk("t4_clear", 0, clr_w[0], 1);
        cyc();
        flush = 1'b0;
        #3;
        chk("t4_clear_held", 0, clr_w[0], 1);
        chk("t4_no_loadl", 0, ll_w[0], 0);
        cyc();
        #3;
        chk("t4_reg_cleared", 0, dreg[0], 16'h0000);
        chk("t4_clear_end", 0, clr_w[0], 0);
        cyc();
        send(8'h77);
        send(8'h88);
        cyc();
        #3;
        chk("t4_reg", 0, dreg[0], 16'h7788);
        chk("t4_reg_c", 2, dreg[2], 16'h7788);
        cyc();
        ack();

        // 5: reset during COMMIT, then flush beats ack in FULL
        send(8'h99);
        send(8'hAA);
        clear_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_rst_strobes", i, {lh_w[i], ll_w[i]}, 2'b00);
            chk("t5_rst_data", i, {inh_w[i], inl_w[i]}, 16'h0000);
            chk("t5_rst_valid", i, wv_w[i], 0);
            chk("t5_rst_count", i, cnt_w[i], 0);
        end
        cyc();
        clear_n = 1'b1;
        cyc();
        #3;
        chk("t5_no_strobe", 0, {lh_w[0], ll_w[0]}, 2'b00);
        cyc();
        send(8'h12);
        send(8'h34);
        cyc();
        flush = 1'b1;
        word_ack = 1'b1;
        cyc();
        flush = 1'b0;
        word_ack = 1'b0;
        #3;
        chk("t5_count_kept", 0, cnt_w[0], 0);
        chk("t5_valid_drop", 0, wv_w[0], 0);
        chk("t5_clear", 0, clr_w[0], 1);
        cyc();

        // 6: 2-bit counter wraps
        for (int k = 0; k < 5; k++) begin
            send(8'(k));
            send(8'(k + 16));
            cyc();
            ack();
            #3;
            chk("t6_count_wrap", 2, cnt_w[2], exp_c[k]);
            cyc();
        end
        chk("t6_count_wide", 0, cnt_w[0], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
